box_filter_h: RTL and testbench

- Parametrised horizontal moving-average (box) filter for the RGB video stream.
- Successor to the fixed 8-sample averaging stage: window length and channel width are parameters; per-channel RGB or luma-style gray mode is selectable.
- Sits between the pixel source and downstream image-processing stages.
- Passes hsync/vsync/en through, delayed to match the data latency.

---
 rtl/box_filter_h.sv | 130 +++++++++++++
 tb/tb_box_filter_h.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/box_filter_h.sv
// Horizontal moving-average (box) filter over N = 1<<WIN_LOG2 pixels, per-channel or gray.
// Optional round-half-up arithmetic when BOX_FILTER_ROUND_EN is defined.
module box_filter_h #(
    parameter int DW       = 8,
    parameter int WIN_LOG2 = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hsync,
    input  logic            vsync,
    input  logic            en,
    input  logic            mode,
    input  logic [3*DW-1:0] in_data,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_en,
    output logic [3*DW-1:0] out_data
);

    localparam int N = 1 << WIN_LOG2;
`ifdef BOX_FILTER_ROUND_EN
    localparam int AW = DW + WIN_LOG2 + 1;
    localparam logic [DW+1:0] G_BIAS = (DW+2)'(2);
    localparam logic [AW-1:0] R_BIAS = AW'(N >> 1);
`else
    localparam int AW = DW + WIN_LOG2;
    localparam logic [DW+1:0] G_BIAS = '0;
    localparam logic [AW-1:0] R_BIAS = '0;
`endif

    // Stage 1: input register, run-start detect, mode latch
    logic [3*DW-1:0] s1_data;
    logic            s1_en, s1_start, s1_hs, s1_vs;
    logic            run_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_en    <= 1'b0;
            s1_start <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            run_mode <= 1'b0;
        end else begin
            s1_data  <= in_data;
            s1_en    <= en;
            s1_start <= en & ~s1_en;
            s1_hs    <= hsync;
            s1_vs    <= vsync;
            if (en && !s1_en)
                run_mode <= mode;
        end
    end

    // Stage 2: lane sample selection, tap window and running sums
    logic [DW+1:0] g_sum;
    logic [DW-1:0] lane_in [3];

    always_comb begin
        g_sum = {2'b00, s1_data[3*DW-1 -: DW]}
              + {1'b0, s1_data[2*DW-1 -: DW], 1'b0}
              + {2'b00, s1_data[DW-1 -: DW]}
              + G_BIAS;
        for (int l = 0; l < 3; l++)
            lane_in[l] = run_mode ? g_sum[DW+1:2] : s1_data[l*DW +: DW];
    end

    logic [DW-1:0] taps [3][N];
    logic [AW-1:0] acc  [3];
    logic          s2_en, s2_hs, s2_vs;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_en <= 1'b0;
            s2_hs <= 1'b0;
            s2_vs <= 1'b0;
            for (int l = 0; l < 3; l++) begin
                acc[l] <= '0;
                for (int k = 0; k < N; k++)
                    taps[l][k] <= '0;
            end
        end else begin
            s2_en <= s1_en;
            s2_hs <= s1_hs;
            s2_vs <= s1_vs;
            if (s1_en) begin
                for (int l = 0; l < 3; l++) begin
                    if (s1_start) begin
                        // Edge replication: the window starts full of the first sample
                        for (int k = 0; k < N; k++)
                            taps[l][k] <= lane_in[l];
                        acc[l] <= AW'(lane_in[l]) << WIN_LOG2;
                    end else begin
                        taps[l][0] <= lane_in[l];
                        for (int k = 1; k < N; k++)
                            taps[l][k] <= taps[l][k-1];
                        acc[l] <= acc[l] + AW'(lane_in[l]) - AW'(taps[l][N-1]);
                    end
                end
            end
        end
    end

    // Stage 3: divide by N and register outputs
    logic [AW-1:0]   rnd [3];
    logic [3*DW-1:0] avg_px;

    always_comb begin
        avg_px = '0;
        for (int l = 0; l < 3; l++) begin
            rnd[l] = acc[l] + R_BIAS;
            avg_px[l*DW +: DW] = rnd[l][WIN_LOG2 +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_en     <= 1'b0;
            o_hsync  <= 1'b0;
            o_vsync  <= 1'b0;
            out_data <= '0;
        end else begin
            o_en     <= s2_en;
            o_hsync  <= s2_hs;
            o_vsync  <= s2_vs;
            out_data <= s2_en ? avg_px : '0;
        end
    end

endmodule

// File: tb/tb_box_filter_h.sv
// Directed bench for box_filter_h (DW=8, N=4): expected pixels queued at drive time,
// a negedge monitor checks data, sync delays and zeroing.
module tb_box_filter_h;

    localparam int DW       = 8;
    localparam int WIN_LOG2 = 2;
    localparam int PW       = 3 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hsync = 1'b0;
    logic          vsync = 1'b0;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          o_hsync, o_vsync, o_en;
    logic [PW-1:0] out_data;

    box_filter_h #(.DW(DW), .WIN_LOG2(WIN_LOG2)) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .en(en), .mode(mode),
        .in_data(in_data), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_en(o_en),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    logic [PW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;
    logic          mon_on = 1'b0;
    logic [2:0]    sync_d [3] = '{3'b000, 3'b000, 3'b000};
    logic [7:0]    step_r [8];

    task automatic cyc(input logic r, input logic e, input logic m, input logic [PW-1:0] d);
        @(posedge clk);
        #1;
        rst     = r;
        en      = e;
        mode    = m;
        in_data = d;
        hsync   = 1'($urandom_range(0, 1));
        vsync   = 1'($urandom_range(0, 1));
    endtask

    task automatic px(input logic m, input logic [PW-1:0] d, input logic [PW-1:0] exp_px);
        cyc(1'b0, 1'b1, m, d);
        exp_q.push_back(exp_px);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), PW'($urandom));
    endtask

    // Monitor: 3-cycle delay model for syncs, scoreboard for data
    always @(negedge clk) begin
        logic [PW-1:0] e_px;
        if (mon_on) begin
            checks++;
            if ({o_hsync, o_vsync, o_en} !== sync_d[2]) begin
                errors++;
                $display("FAIL sync_delay got %b want %b", {o_hsync, o_vsync, o_en}, sync_d[2]);
            end
            checks++;
            if (o_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel got %h want none", out_data);
                end else begin
                    e_px = exp_q.pop_front();
                    if (out_data !== e_px) begin
                        errors++;
                        $display("FAIL pixel got %h want %h", out_data, e_px);
                    end
                end
            end else if (out_data !== '0) begin
                errors++;
                $display("FAIL idle_zero got %h want 0", out_data);
            end
        end
        if (rst) begin
            sync_d <= '{3'b000, 3'b000, 3'b000};
        end else begin
            sync_d[0] <= {hsync, vsync, en};
            sync_d[1] <= sync_d[0];
            sync_d[2] <= sync_d[1];
        end
    end

    initial begin
`ifdef BOX_FILTER_ROUND_EN
        step_r = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd5, 8'd8, 8'd10};
`else
        step_r = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd5, 8'd7, 8'd10};
`endif
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        // Reset with random inputs
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PW'($urandom));
        idle(3);

        // Constant run, edge replication
        for (int i = 0; i < 10; i++) px(1'b0, 24'h102030, 24'h102030);
        idle(2);

        // Step on R lane
        for (int i = 0; i < 8; i++)
            px(1'b0, (i < 4) ? 24'h000000 : 24'h0A0000, {step_r[i], 16'h0000});
        idle(2);

        // Gray mode
        for (int i = 0; i < 5; i++) px(1'b1, 24'h285078, 24'h505050);
        idle(2);

        // Run isolation with a one-cycle gap
        for (int i = 0; i < 6; i++) px(1'b0, 24'hFFFFFF, 24'hFFFFFF);
        idle(1);
        for (int i = 0; i < 6; i++) px(1'b0, 24'h000000, 24'h000000);
        idle(2);

        // Single-pixel run
        px(1'b0, 24'h123456, 24'h123456);
        idle(2);

        // Mode toggled mid-run is ignored; next run picks up gray
        for (int i = 0; i < 6; i++) px((i >= 2), 24'h102030, 24'h102030);
        idle(1);
        for (int i = 0; i < 4; i++) px(1'b1, 24'h102030, 24'h202020);
        idle(2);

        // Reset at run pixel 4: only pixel 1 escapes before the flush
        px(1'b0, 24'h0A0B0C, 24'h0A0B0C);
        cyc(1'b0, 1'b1, 1'b0, 24'h0A0B0C);
        cyc(1'b0, 1'b1, 1'b0, 24'h0A0B0C);
        cyc(1'b1, 1'b1, 1'b0, 24'h0A0B0C);
        for (int i = 0; i < 4; i++) px(1'b0, 24'h404040, 24'h404040);
        idle(2);
        // Fresh replication after a run that ends with a non-constant window
        px(1'b0, 24'h080000, 24'h080000);
        px(1'b0, 24'h000000, 24'h060000);
        idle(1);
        px(1'b0, 24'h000010, 24'h000010);
        idle(2);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
